// File: rtl/traffic_slot_memory.sv
// Per-slot traffic store: live count/rank arrays with saturating accumulate, a registered read
// port, whole-array rank load and a snapshot dump streamed over valid/ready.
module traffic_slot_memory #(
  parameter int unsigned NUM_SLOTS = 24,
  parameter int unsigned DATA_W    = 15,
  parameter int unsigned RANK_W    = 5,
  localparam int unsigned SLOT_W   = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          acc_valid,
  input  logic                          acc_mode,
  input  logic [SLOT_W-1:0]             acc_slot,
  input  logic [DATA_W-1:0]             acc_data,
  input  logic                          rank_wr,
  input  logic [NUM_SLOTS*RANK_W-1:0]   rank_data,
  input  logic [SLOT_W-1:0]             rd_slot,
  output logic [DATA_W-1:0]             rd_data,
  input  logic                          dump_start,
  output logic                          dump_busy,
  output logic                          dump_valid,
  input  logic                          dump_ready,
  output logic [SLOT_W-1:0]             dump_slot,
  output logic [DATA_W-1:0]             dump_data,
  output logic [RANK_W-1:0]             dump_rank,
  output logic                          sat_flag,
  output logic                          err_flag
);

  typedef enum logic [1:0] {StIdle, StLoad, StStream} dump_state_e;

  localparam logic [SLOT_W:0]   NumSlotsExt = (SLOT_W + 1)'(NUM_SLOTS);
  localparam logic [SLOT_W-1:0] LastSlot    = SLOT_W'(NUM_SLOTS - 1);
  localparam logic [DATA_W-1:0] CountMax    = '1;

  logic [DATA_W-1:0] cnt_q       [NUM_SLOTS];
  logic [DATA_W-1:0] cnt_d       [NUM_SLOTS];
  logic [RANK_W-1:0] rank_q      [NUM_SLOTS];
  logic [RANK_W-1:0] rank_d      [NUM_SLOTS];
  logic [DATA_W-1:0] snap_cnt_q  [NUM_SLOTS];
  logic [RANK_W-1:0] snap_rank_q [NUM_SLOTS];

  logic [DATA_W-1:0] rd_data_q;
  logic              sat_q, sat_d;
  logic              err_q, err_d;
  dump_state_e       state_q, state_d;
  logic [SLOT_W-1:0] idx_q, idx_d;
  logic              snap_load;

  logic              acc_in_range;
  logic              rd_in_range;
  logic [DATA_W-1:0] acc_cur;
  logic [DATA_W:0]   acc_sum;
  logic [DATA_W-1:0] acc_result;

  assign acc_in_range = {1'b0, acc_slot} < NumSlotsExt;
  assign rd_in_range  = {1'b0, rd_slot} < NumSlotsExt;

  // Live array next state; the snapshot copies this so a same-cycle update lands in the dump.
  always_comb begin
    cnt_d   = cnt_q;
    rank_d  = rank_q;
    sat_d   = sat_q;
    err_d   = err_q;
    acc_cur = '0;
    if (acc_in_range) begin
      acc_cur = cnt_q[acc_slot];
    end
    acc_sum    = {1'b0, acc_cur} + {1'b0, acc_data};
    acc_result = acc_data;
    if (acc_mode) begin
      acc_result = acc_sum[DATA_W] ? CountMax : acc_sum[DATA_W-1:0];
    end
    if (acc_valid) begin
      if (acc_in_range) begin
        cnt_d[acc_slot] = acc_result;
        sat_d           = sat_q | (acc_mode & acc_sum[DATA_W]);
      end else begin
        err_d = 1'b1;
      end
    end
    if (rank_wr) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        rank_d[i] = rank_data[i*RANK_W +: RANK_W];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    snap_load = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (dump_start) begin
          state_d = StLoad;
        end
      end
      StLoad: begin
        snap_load = 1'b1;
        idx_d     = '0;
        state_d   = StStream;
      end
      StStream: begin
        if (dump_ready) begin
          if (idx_q == LastSlot) begin
            state_d = StIdle;
          end else begin
            idx_d = idx_q + SLOT_W'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        cnt_q[i]       <= '0;
        rank_q[i]      <= '0;
        snap_cnt_q[i]  <= '0;
        snap_rank_q[i] <= '0;
      end
      rd_data_q <= '0;
      sat_q     <= 1'b0;
      err_q     <= 1'b0;
      state_q   <= StIdle;
      idx_q     <= '0;
    end else begin
      cnt_q  <= cnt_d;
      rank_q <= rank_d;
      if (snap_load) begin
        snap_cnt_q  <= cnt_d;
        snap_rank_q <= rank_d;
      end
      // Reads the pre-update array, so a same-cycle write is not forwarded.
      rd_data_q <= rd_in_range ? cnt_q[rd_slot] : '0;
      sat_q     <= sat_d;
      err_q     <= err_d;
      state_q   <= state_d;
      idx_q     <= idx_d;
    end
  end

  assign rd_data    = rd_data_q;
  assign sat_flag   = sat_q;
  assign err_flag   = err_q;
  assign dump_busy  = (state_q != StIdle);
  assign dump_valid = (state_q == StStream);
  assign dump_slot  = idx_q;
  assign dump_data  = snap_cnt_q[idx_q];
  assign dump_rank  = snap_rank_q[idx_q];

endmodule
